// File: rtl/monolith_round_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : monolith_round_sequencer
// Description : Drives an iterative Monolith round engine through a pre-round
//               and ROUND_COUNT full rounds. Optional MONOLITH_SEQ_TIMEOUT_EN
//               adds a WAIT-state watchdog with a sticky timeout_err output.
// Revision    : 1.0 - initial release
// ============================================================================
module monolith_round_sequencer #(
   parameter int WORD_WIDTH     = 31,
   parameter int STATE_SIZE     = 16,
   parameter int ROUND_COUNT    = 6,
`ifdef MONOLITH_SEQ_TIMEOUT_EN
   parameter int TIMEOUT_CYCLES = 64,
`endif
   parameter int RC_AW          = $clog2(ROUND_COUNT)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WORD_WIDTH-1:0] in_state   [0:STATE_SIZE-1],
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WORD_WIDTH-1:0] out_state  [0:STATE_SIZE-1],
   output logic                  rnd_load,
   output logic                  rnd_pre,
   output logic [WORD_WIDTH-1:0] rnd_state  [0:STATE_SIZE-1],
   output logic [WORD_WIDTH-1:0] rnd_const  [0:STATE_SIZE-1],
   input  logic                  rnd_valid,
   input  logic [WORD_WIDTH-1:0] rnd_result [0:STATE_SIZE-1],
   output logic [RC_AW-1:0]      rc_addr,
   input  logic [WORD_WIDTH-1:0] rc_data    [0:STATE_SIZE-1]
`ifdef MONOLITH_SEQ_TIMEOUT_EN
   ,
   output logic                  timeout_err
`endif
);

   localparam int c_IDX_W = $clog2(ROUND_COUNT + 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_GUARD = 3'd2,
      S_WAIT  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t                r_fsm;
   state_t                w_fsm_nxt;
   logic [WORD_WIDTH-1:0] r_state [0:STATE_SIZE-1];
   logic [c_IDX_W-1:0]    r_round_idx;
   logic                  w_last_round;
   logic                  w_timeout_hit;

   assign w_last_round = (r_round_idx == c_IDX_W'(ROUND_COUNT));

`ifdef MONOLITH_SEQ_TIMEOUT_EN
   localparam int c_TO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [c_TO_W-1:0] r_to_cnt;
   logic              r_timeout_err;

   assign w_timeout_hit = (r_fsm == S_WAIT) && !rnd_valid &&
                          (r_to_cnt == c_TO_W'(TIMEOUT_CYCLES - 1));
   assign timeout_err   = r_timeout_err;

   // GUARD always precedes WAIT, so clearing there is the WAIT entry clear
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_to_cnt      <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         if (r_fsm == S_GUARD)
            r_to_cnt <= '0;
         else if (r_fsm == S_WAIT && !rnd_valid)
            r_to_cnt <= r_to_cnt + c_TO_W'(1);
         if (w_timeout_hit)
            r_timeout_err <= 1'b1;
      end
   end
`else
   assign w_timeout_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_fsm <= S_IDLE;
      else
         r_fsm <= w_fsm_nxt;
   end

   always_comb begin
      w_fsm_nxt = r_fsm;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      rnd_load  = 1'b0;
      case (r_fsm)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid)
               w_fsm_nxt = S_LOAD;
         end
         S_LOAD: begin
            rnd_load  = 1'b1;
            w_fsm_nxt = S_GUARD;
         end
         // Engine's concrete stage is clearing; its valid is not trustworthy here
         S_GUARD: w_fsm_nxt = S_WAIT;
         S_WAIT: begin
            if (rnd_valid)
               w_fsm_nxt = w_last_round ? S_DONE : S_LOAD;
            else if (w_timeout_hit)
               w_fsm_nxt = S_IDLE;
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready)
               w_fsm_nxt = S_IDLE;
         end
         default: w_fsm_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_round_idx <= '0;
         for (int i = 0; i < STATE_SIZE; i++)
            r_state[i] <= '0;
      end else begin
         if (r_fsm == S_IDLE && in_valid) begin
            r_round_idx <= '0;
            for (int i = 0; i < STATE_SIZE; i++)
               r_state[i] <= in_state[i];
         end else if (r_fsm == S_WAIT && rnd_valid) begin
            for (int i = 0; i < STATE_SIZE; i++)
               r_state[i] <= rnd_result[i];
            if (!w_last_round)
               r_round_idx <= r_round_idx + c_IDX_W'(1);
         end
      end
   end

   assign rnd_pre   = (r_round_idx == '0);
   assign rnd_state = r_state;
   assign out_state = r_state;
   assign rc_addr   = rnd_pre ? '0 : RC_AW'(r_round_idx - c_IDX_W'(1));

   always_comb begin
      for (int i = 0; i < STATE_SIZE; i++)
         rnd_const[i] = rnd_pre ? '0 : rc_data[i];
   end

endmodule
`default_nettype wire

// File: tb/tb_monolith_round_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_monolith_round_sequencer
// Description : Directed bench with a latency-3 stub engine and constant ROM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_monolith_round_sequencer;

   localparam int WW = 31;
   localparam int SS = 16;
   localparam int RC = 6;
   localparam int AW = $clog2(RC);

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [WW-1:0] in_state   [0:SS-1];
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [WW-1:0] out_state  [0:SS-1];
   logic          rnd_load;
   logic          rnd_pre;
   logic [WW-1:0] rnd_state  [0:SS-1];
   logic [WW-1:0] rnd_const  [0:SS-1];
   logic          rnd_valid;
   logic [WW-1:0] rnd_result [0:SS-1];
   logic [AW-1:0] rc_addr;
   logic [WW-1:0] rc_data    [0:SS-1];
`ifdef MONOLITH_SEQ_TIMEOUT_EN
   logic          timeout_err;
`endif

   int checks = 0;
   int errors = 0;

   // stub engine controls
   logic       busy;
   logic [2:0] cnt;
   bit         spur    = 1'b0;
   bit         force_v = 1'b0;
   bit         mute    = 1'b0;

   always #5 clk = ~clk;

   monolith_round_sequencer #(
      .WORD_WIDTH (WW),
      .STATE_SIZE (SS),
      .ROUND_COUNT(RC)
`ifdef MONOLITH_SEQ_TIMEOUT_EN
      ,
      .TIMEOUT_CYCLES(8)
`endif
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_state  (in_state),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_state (out_state),
      .rnd_load  (rnd_load),
      .rnd_pre   (rnd_pre),
      .rnd_state (rnd_state),
      .rnd_const (rnd_const),
      .rnd_valid (rnd_valid),
      .rnd_result(rnd_result),
      .rc_addr   (rc_addr),
      .rc_data   (rc_data)
`ifdef MONOLITH_SEQ_TIMEOUT_EN
      ,
      .timeout_err(timeout_err)
`endif
   );

   // ROM: word = round index + 1, round index = rc_addr + 1
   always_comb begin
      for (int i = 0; i < SS; i++)
         rc_data[i] = WW'(rc_addr) + WW'(2);
   end

   // Stub engine, latency 3: valid in the third cycle after GUARD
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy <= 1'b0;
         cnt  <= '0;
         for (int i = 0; i < SS; i++)
            rnd_result[i] <= '0;
      end else if (rnd_load) begin
         busy <= 1'b1;
         cnt  <= 3'd1;
         for (int i = 0; i < SS; i++)
            rnd_result[i] <= rnd_state[i] + rnd_const[i] + WW'(1);
      end else if (busy) begin
         if (cnt == 3'd4) begin
            busy <= 1'b0;
            cnt  <= '0;
         end else begin
            cnt <= cnt + 3'd1;
         end
      end
   end

   assign rnd_valid = !mute &&
                      (force_v || (busy && (cnt == 3'd4 || (spur && cnt == 3'd1))));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic set_input(input int v);
      for (int i = 0; i < SS; i++)
         in_state[i] = WW'(v);
   endtask

   // Accept state of 5s, follow the run to out_valid, checking every load
   task automatic run_check(input bit hold_valid);
      int cyc;
      int loads;
      logic [31:0] exp_st;
      logic [31:0] exp_c;
      chk("accept_ready", {31'd0, in_ready}, 32'd1);
      set_input(5);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      if (hold_valid) set_input(7);
      else in_valid = 1'b0;
      cyc    = 1;
      loads  = 0;
      exp_st = 32'd5;
      while (!out_valid && cyc < 200) begin
         if (rnd_load) begin
            exp_c = (loads == 0) ? 32'd0 : 32'(loads + 1);
            chk("load_cycle", 32'(cyc), 32'(1 + 5 * loads));
            chk("load_pre", {31'd0, rnd_pre}, (loads == 0) ? 32'd1 : 32'd0);
            chk("load_rc_addr", 32'(rc_addr), (loads == 0) ? 32'd0 : 32'(loads - 1));
            chk("load_const0", 32'(rnd_const[0]), exp_c);
            chk("load_const15", 32'(rnd_const[SS-1]), exp_c);
            chk("load_state0", 32'(rnd_state[0]), exp_st);
            exp_st = exp_st + exp_c + 32'd1;
            loads++;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      in_valid = 1'b0;
      chk("latency", 32'(cyc), 32'd36);
      chk("load_count", 32'(loads), 32'd7);
      chk("out_word0", 32'(out_state[0]), 32'd39);
      chk("out_word15", 32'(out_state[SS-1]), 32'd39);
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("release_in_ready", {31'd0, in_ready}, 32'd1);
      chk("release_out_valid", {31'd0, out_valid}, 32'd0);
   endtask

   initial begin
      set_input(0);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_rnd_load", {31'd0, rnd_load}, 32'd0);
      chk("rst_out_state", 32'(out_state[0]), 32'd0);
      chk("rst_rc_addr", 32'(rc_addr), 32'd0);
      chk("rst_rnd_const", 32'(rnd_const[0]), 32'd0);
      #2 reset = 1'b1;
      @(posedge clk);
      #1;

      // nominal run with back-pressure and spurious engine valid in DONE
      run_check(1'b0);
      force_v = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         #1;
         chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
         chk("bp_out_state", 32'(out_state[0]), 32'd39);
         chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      end
      force_v = 1'b0;
      release_out();

      // spurious valid in GUARD, in_valid held high with other data
      spur = 1'b1;
      run_check(1'b1);
      spur = 1'b0;
      release_out();

      // reset during round 3 WAIT
      set_input(5);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (18) @(posedge clk);
      #1;
      chk("pre_abort_ready", {31'd0, in_ready}, 32'd0);
      #2 reset = 1'b0;
      #1;
      chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
      chk("abort_rnd_load", {31'd0, rnd_load}, 32'd0);
      chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #3 reset = 1'b1;
      @(posedge clk);
      #1;
      run_check(1'b0);
      release_out();

      // engine valid while idle must not start anything
      force_v = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("idle_force_ready", {31'd0, in_ready}, 32'd1);
      chk("idle_force_load", {31'd0, rnd_load}, 32'd0);
      force_v = 1'b0;

`ifdef MONOLITH_SEQ_TIMEOUT_EN
      mute = 1'b1;
      set_input(5);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      chk("to_before_err", {31'd0, timeout_err}, 32'd0);
      chk("to_before_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
      chk("to_err", {31'd0, timeout_err}, 32'd1);
      chk("to_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      chk("to_sticky", {31'd0, timeout_err}, 32'd1);
      mute = 1'b0;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
